// File: rtl/axis_width_bridge.sv
// rtl/axis_width_bridge.sv - narrow host AXIS to wide core word bridge with input/output FIFOs

module axis_width_bridge_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             arstn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    // The extra pointer bit tells a wrapped (full) FIFO apart from an empty one.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr[AW-1:0]];

    // Storage and pointers; storage is cleared so the head reads zero out of reset.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem[wr_ptr[AW-1:0]] <= push_data;
                wr_ptr              <= wr_ptr + (AW+1)'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end
endmodule

module axis_width_bridge #(
    parameter int BUS_WIDTH  = 8,
    parameter int INP_WIDTH  = 24,
    parameter int OUT_WIDTH  = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           arstn,
    input  logic [BUS_WIDTH-1:0]           s_axis_tdata,
    input  logic                           s_axis_tvalid,
    output logic                           s_axis_tready,
    input  logic                           s_axis_tlast,
    output logic [INP_WIDTH-1:0]           core_in_tdata,
    output logic                           core_in_tvalid,
    input  logic                           core_in_tready,
    input  logic [OUT_WIDTH-1:0]           core_out_tdata,
    input  logic                           core_out_tvalid,
    output logic                           core_out_tready,
    output logic [BUS_WIDTH-1:0]           m_axis_tdata,
    output logic                           m_axis_tvalid,
    input  logic                           m_axis_tready,
    output logic                           m_axis_tlast,
    output logic                           short_word,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] in_level
);
    localparam int IN_BEATS  = INP_WIDTH / BUS_WIDTH;
    localparam int OUT_BEATS = OUT_WIDTH / BUS_WIDTH;
    localparam int ICW       = (IN_BEATS > 1) ? $clog2(IN_BEATS) : 1;
    localparam int OCW       = (OUT_BEATS > 1) ? $clog2(OUT_BEATS) : 1;
    localparam int LW        = $clog2(FIFO_DEPTH+1);

    // ---------------- packer + input FIFO ----------------
    logic [ICW-1:0]       beat_cnt;
    logic [INP_WIDTH-1:0] asm_data;
    logic [INP_WIDTH-1:0] word_next;
    logic                 in_full;
    logic                 in_empty;
    logic                 s_accept;
    logic                 beat_is_last;
    logic                 word_close;
    logic                 in_pop;
    logic [LW-1:0]        level_q;

    // Ready depends only on registered occupancy, so a pop this cycle frees space only next cycle.
    assign s_axis_tready  = arstn && !in_full;
    assign s_accept       = s_axis_tvalid && s_axis_tready;
    assign beat_is_last   = (beat_cnt == ICW'(IN_BEATS-1));
    assign word_close     = s_accept && (s_axis_tlast || beat_is_last);
    assign core_in_tvalid = !in_empty;
    assign in_pop         = core_in_tvalid && core_in_tready;
    assign in_level       = level_q;

    // Merge the current beat into its slice; beat 0 is the MSB slice, unfilled slices stay zero.
    always_comb begin
        word_next = asm_data | (INP_WIDTH'(s_axis_tdata) << ((IN_BEATS-1-int'(beat_cnt))*BUS_WIDTH));
    end

    // Beat counter, assembly register and the early-close pulse.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            beat_cnt   <= '0;
            asm_data   <= '0;
            short_word <= 1'b0;
        end else begin
            short_word <= word_close && s_axis_tlast && !beat_is_last;
            if (s_accept) begin
                if (word_close) begin
                    beat_cnt <= '0;
                    asm_data <= '0;
                end else begin
                    beat_cnt <= beat_cnt + ICW'(1);
                    asm_data <= word_next;
                end
            end
        end
    end

    // Input occupancy: a push only happens when not full, a pop only when not empty.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            level_q <= '0;
        end else if (word_close && !in_pop) begin
            level_q <= level_q + LW'(1);
        end else if (in_pop && !word_close) begin
            level_q <= level_q - LW'(1);
        end
    end

    axis_width_bridge_fifo #(
        .WIDTH (INP_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_in_fifo (
        .clk       (clk),
        .arstn     (arstn),
        .push      (word_close),
        .push_data (word_next),
        .pop       (in_pop),
        .head      (core_in_tdata),
        .full      (in_full),
        .empty     (in_empty)
    );

    // ---------------- output FIFO + unpacker ----------------
    logic [OUT_WIDTH-1:0] out_head;
    logic                 out_full;
    logic                 out_empty;
    logic                 out_push;
    logic                 out_pop;
    logic                 m_hs;
    logic                 idx_last;
    logic [OCW-1:0]       idx;

    assign core_out_tready = arstn && !out_full;
    assign out_push        = core_out_tvalid && core_out_tready;
    assign m_axis_tvalid   = !out_empty;
    assign m_hs            = m_axis_tvalid && m_axis_tready;
    assign idx_last        = (idx == OCW'(OUT_BEATS-1));
    assign out_pop         = m_hs && idx_last;
    assign m_axis_tlast    = m_axis_tvalid && idx_last;
    assign m_axis_tdata    = BUS_WIDTH'(out_head >> ((OUT_BEATS-1-int'(idx))*BUS_WIDTH));

    // Beat index into the head word; the head only pops after its last beat is taken.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            idx <= '0;
        end else if (m_hs) begin
            idx <= idx_last ? '0 : idx + OCW'(1);
        end
    end

    axis_width_bridge_fifo #(
        .WIDTH (OUT_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_out_fifo (
        .clk       (clk),
        .arstn     (arstn),
        .push      (out_push),
        .push_data (core_out_tdata),
        .pop       (out_pop),
        .head      (out_head),
        .full      (out_full),
        .empty     (out_empty)
    );
endmodule

// File: tb/tb_axis_width_bridge.sv
// tb/tb_axis_width_bridge.sv - directed testbench for axis_width_bridge

module tb_axis_width_bridge;
    logic        clk;
    logic        arstn;
    logic [7:0]  s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic        s_axis_tlast;
    logic [23:0] core_in_tdata;
    logic        core_in_tvalid;
    logic        core_in_tready;
    logic [15:0] core_out_tdata;
    logic        core_out_tvalid;
    logic        core_out_tready;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic        short_word;
    logic [2:0]  in_level;

    int n_vec = 0;
    int n_err = 0;
    int sw_count = 0;

    axis_width_bridge #(
        .BUS_WIDTH  (8),
        .INP_WIDTH  (24),
        .OUT_WIDTH  (16),
        .FIFO_DEPTH (4)
    ) dut (
        .clk             (clk),
        .arstn           (arstn),
        .s_axis_tdata    (s_axis_tdata),
        .s_axis_tvalid   (s_axis_tvalid),
        .s_axis_tready   (s_axis_tready),
        .s_axis_tlast    (s_axis_tlast),
        .core_in_tdata   (core_in_tdata),
        .core_in_tvalid  (core_in_tvalid),
        .core_in_tready  (core_in_tready),
        .core_out_tdata  (core_out_tdata),
        .core_out_tvalid (core_out_tvalid),
        .core_out_tready (core_out_tready),
        .m_axis_tdata    (m_axis_tdata),
        .m_axis_tvalid   (m_axis_tvalid),
        .m_axis_tready   (m_axis_tready),
        .m_axis_tlast    (m_axis_tlast),
        .short_word      (short_word),
        .in_level        (in_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (short_word === 1'b1) sw_count++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    task automatic send_beat(input logic [7:0] d, input logic l);
        int budget;
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        #1;
        budget = 0;
        while (s_axis_tready !== 1'b1 && budget < 50) begin
            @(negedge clk); #1;
            budget++;
        end
        n_vec++;
        if (s_axis_tready !== 1'b1) begin
            n_err++;
            $display("FAIL send_beat_ready: got %b want 1", s_axis_tready);
        end
        @(negedge clk);
    endtask

    task automatic idle_in();
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tdata  = 8'h00;
    endtask

    task automatic test_reset();
        arstn = 1'b0;
        s_axis_tdata = 8'h00; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
        core_in_tready = 1'b0; core_out_tdata = 16'h0; core_out_tvalid = 1'b0;
        m_axis_tready = 1'b0;
        #1;
        n_vec++; if ({s_axis_tready, core_in_tvalid, core_out_tready, m_axis_tvalid, m_axis_tlast, short_word} !== 6'b0) begin n_err++; $display("FAIL reset_ctrl: got %b want 000000", {s_axis_tready, core_in_tvalid, core_out_tready, m_axis_tvalid, m_axis_tlast, short_word}); end
        n_vec++; if ({core_in_tdata, m_axis_tdata, in_level} !== 35'h0) begin n_err++; $display("FAIL reset_data: got %h want 0", {core_in_tdata, m_axis_tdata, in_level}); end
        repeat (3) @(negedge clk);
        arstn = 1'b1;
        #1;
        n_vec++; if (s_axis_tready !== 1'b1) begin n_err++; $display("FAIL post_reset_s_ready: got %b want 1", s_axis_tready); end
        n_vec++; if (core_out_tready !== 1'b1) begin n_err++; $display("FAIL post_reset_out_ready: got %b want 1", core_out_tready); end
        @(negedge clk);
    endtask

    task automatic test_full_word();
        int base;
        base = sw_count;
        core_in_tready = 1'b0;
        send_beat(8'hAA, 1'b0);
        send_beat(8'hBB, 1'b0);
        n_vec++; if (core_in_tvalid !== 1'b0) begin n_err++; $display("FAIL full_early_valid: got %b want 0", core_in_tvalid); end
        send_beat(8'hCC, 1'b1);
        idle_in();
        n_vec++; if (core_in_tvalid !== 1'b1) begin n_err++; $display("FAIL full_valid: got %b want 1", core_in_tvalid); end
        n_vec++; if (core_in_tdata !== 24'hAABBCC) begin n_err++; $display("FAIL full_data: got %h want aabbcc", core_in_tdata); end
        n_vec++; if (in_level !== 3'd1) begin n_err++; $display("FAIL full_level: got %0d want 1", in_level); end
        @(negedge clk);
        n_vec++; if (sw_count != base) begin n_err++; $display("FAIL full_no_short: got %0d pulses want 0", sw_count - base); end
        core_in_tready = 1'b1;
        @(negedge clk);
        core_in_tready = 1'b0;
        n_vec++; if (in_level !== 3'd0 || core_in_tvalid !== 1'b0) begin n_err++; $display("FAIL full_pop: got level %0d valid %b want 0 0", in_level, core_in_tvalid); end
    endtask

    task automatic test_short_word();
        int base;
        base = sw_count;
        send_beat(8'h11, 1'b0);
        send_beat(8'h22, 1'b1);
        idle_in();
        n_vec++; if (core_in_tdata !== 24'h112200) begin n_err++; $display("FAIL short_data: got %h want 112200", core_in_tdata); end
        n_vec++; if (short_word !== 1'b1) begin n_err++; $display("FAIL short_pulse: got %b want 1", short_word); end
        repeat (2) @(negedge clk);
        n_vec++; if (short_word !== 1'b0) begin n_err++; $display("FAIL short_clear: got %b want 0", short_word); end
        n_vec++; if (sw_count - base != 1) begin n_err++; $display("FAIL short_count: got %0d want 1", sw_count - base); end
        core_in_tready = 1'b1;
        @(negedge clk);
        core_in_tready = 1'b0;
    endtask

    task automatic test_fill();
        logic [23:0] exp_word;
        core_in_tready = 1'b0;
        for (int i = 0; i < 12; i++) send_beat(8'(i+1), 1'b0);
        idle_in();
        n_vec++; if (in_level !== 3'd4) begin n_err++; $display("FAIL fill_level: got %0d want 4", in_level); end
        n_vec++; if (s_axis_tready !== 1'b0) begin n_err++; $display("FAIL fill_ready: got %b want 0", s_axis_tready); end
        n_vec++; if (core_in_tdata !== 24'h010203) begin n_err++; $display("FAIL fill_head0: got %h want 010203", core_in_tdata); end
        core_in_tready = 1'b1;
        #1;
        n_vec++; if (s_axis_tready !== 1'b0) begin n_err++; $display("FAIL fill_no_credit: got %b want 0", s_axis_tready); end
        @(negedge clk);
        core_in_tready = 1'b0;
        #1;
        n_vec++; if (s_axis_tready !== 1'b1) begin n_err++; $display("FAIL fill_ready_back: got %b want 1", s_axis_tready); end
        n_vec++; if (in_level !== 3'd3) begin n_err++; $display("FAIL fill_level3: got %0d want 3", in_level); end
        core_in_tready = 1'b1;
        for (int k = 1; k < 4; k++) begin
            exp_word = {8'(3*k+1), 8'(3*k+2), 8'(3*k+3)};
            n_vec++; if (core_in_tdata !== exp_word || core_in_tvalid !== 1'b1) begin n_err++; $display("FAIL fill_drain%0d: got %h valid %b want %h", k, core_in_tdata, core_in_tvalid, exp_word); end
            @(negedge clk);
        end
        core_in_tready = 1'b0;
        n_vec++; if (in_level !== 3'd0 || core_in_tvalid !== 1'b0) begin n_err++; $display("FAIL fill_empty: got level %0d valid %b want 0 0", in_level, core_in_tvalid); end
    endtask

    task automatic test_unpack();
        m_axis_tready   = 1'b1;
        core_out_tdata  = 16'h1234;
        core_out_tvalid = 1'b1;
        #1;
        n_vec++; if (core_out_tready !== 1'b1) begin n_err++; $display("FAIL unpack_ready: got %b want 1", core_out_tready); end
        @(negedge clk);
        core_out_tvalid = 1'b0;
        n_vec++; if ({m_axis_tvalid, m_axis_tdata, m_axis_tlast} !== {1'b1, 8'h12, 1'b0}) begin n_err++; $display("FAIL unpack_beat0: got v%b %h l%b want v1 12 l0", m_axis_tvalid, m_axis_tdata, m_axis_tlast); end
        @(negedge clk);
        n_vec++; if ({m_axis_tvalid, m_axis_tdata, m_axis_tlast} !== {1'b1, 8'h34, 1'b1}) begin n_err++; $display("FAIL unpack_beat1: got v%b %h l%b want v1 34 l1", m_axis_tvalid, m_axis_tdata, m_axis_tlast); end
        @(negedge clk);
        n_vec++; if (m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL unpack_empty: got %b want 0", m_axis_tvalid); end
    endtask

    task automatic test_stall();
        m_axis_tready   = 1'b0;
        core_out_tdata  = 16'hBEEF;
        core_out_tvalid = 1'b1;
        @(negedge clk);
        core_out_tvalid = 1'b0;
        @(negedge clk);
        n_vec++; if ({m_axis_tvalid, m_axis_tdata, m_axis_tlast} !== {1'b1, 8'hBE, 1'b0}) begin n_err++; $display("FAIL stall_hold_be: got v%b %h l%b want v1 be l0", m_axis_tvalid, m_axis_tdata, m_axis_tlast); end
        m_axis_tready = 1'b1;
        @(negedge clk);
        m_axis_tready = 1'b0;
        n_vec++; if ({m_axis_tdata, m_axis_tlast} !== {8'hEF, 1'b1}) begin n_err++; $display("FAIL stall_ef: got %h l%b want ef l1", m_axis_tdata, m_axis_tlast); end
        @(negedge clk);
        n_vec++; if ({m_axis_tvalid, m_axis_tdata, m_axis_tlast} !== {1'b1, 8'hEF, 1'b1}) begin n_err++; $display("FAIL stall_hold_ef: got v%b %h l%b want v1 ef l1", m_axis_tvalid, m_axis_tdata, m_axis_tlast); end
        m_axis_tready = 1'b1;
        @(negedge clk);
        n_vec++; if (m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL stall_no_dup: got %b want 0", m_axis_tvalid); end
    endtask

    task automatic test_out_full();
        logic [15:0] w;
        logic [7:0]  exp_b;
        m_axis_tready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            core_out_tdata  = {8'(16*i+1), 8'(16*i+2)};
            core_out_tvalid = 1'b1;
            #1;
            n_vec++; if (core_out_tready !== (i < 4)) begin n_err++; $display("FAIL outfull_ready%0d: got %b want %b", i, core_out_tready, (i < 4)); end
            @(negedge clk);
        end
        core_out_tvalid = 1'b0;
        m_axis_tready   = 1'b1;
        for (int b = 0; b < 8; b++) begin
            w = {8'(16*(b/2)+1), 8'(16*(b/2)+2)};
            exp_b = (b % 2 == 0) ? w[15:8] : w[7:0];
            n_vec++; if ({m_axis_tvalid, m_axis_tdata, m_axis_tlast} !== {1'b1, exp_b, (b % 2 == 1)}) begin n_err++; $display("FAIL outfull_beat%0d: got v%b %h l%b want v1 %h l%b", b, m_axis_tvalid, m_axis_tdata, m_axis_tlast, exp_b, (b % 2 == 1)); end
            @(negedge clk);
        end
        n_vec++; if (m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL outfull_drained: got %b want 0", m_axis_tvalid); end
    endtask

    task automatic test_reset_mid();
        int base;
        m_axis_tready   = 1'b0;
        core_out_tdata  = 16'h5566;
        core_out_tvalid = 1'b1;
        @(negedge clk);
        core_out_tvalid = 1'b0;
        core_in_tready  = 1'b0;
        send_beat(8'hEE, 1'b0);
        send_beat(8'hDD, 1'b0);
        idle_in();
        base = sw_count;
        arstn = 1'b0;
        #1;
        n_vec++; if ({s_axis_tready, core_in_tvalid, core_out_tready, m_axis_tvalid, m_axis_tlast, short_word} !== 6'b0) begin n_err++; $display("FAIL midrst_ctrl: got %b want 000000", {s_axis_tready, core_in_tvalid, core_out_tready, m_axis_tvalid, m_axis_tlast, short_word}); end
        n_vec++; if ({core_in_tdata, m_axis_tdata, in_level} !== 35'h0) begin n_err++; $display("FAIL midrst_data: got %h want 0", {core_in_tdata, m_axis_tdata, in_level}); end
        @(negedge clk);
        arstn = 1'b1;
        @(negedge clk);
        send_beat(8'h01, 1'b0);
        send_beat(8'h02, 1'b0);
        send_beat(8'h03, 1'b0);
        idle_in();
        n_vec++; if (core_in_tdata !== 24'h010203 || in_level !== 3'd1) begin n_err++; $display("FAIL midrst_word: got %h level %0d want 010203 level 1", core_in_tdata, in_level); end
        n_vec++; if (m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL midrst_out_cleared: got %b want 0", m_axis_tvalid); end
        core_in_tready = 1'b1;
        @(negedge clk);
        core_in_tready = 1'b0;
        n_vec++; if (core_in_tvalid !== 1'b0) begin n_err++; $display("FAIL midrst_single: got %b want 0", core_in_tvalid); end
        n_vec++; if (sw_count != base) begin n_err++; $display("FAIL midrst_no_short: got %0d pulses want 0", sw_count - base); end
    endtask

    initial begin
        test_reset();
        test_full_word();
        test_short_word();
        test_fill();
        test_unpack();
        test_stall();
        test_out_full();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
